inst_queue_2w2r: RTL and testbench
==================================

# inst_queue_2w2r

Dual-write / dual-read instruction queue between fetch and the two issue lanes of the superscalar MIPS core. Fetch pushes up to two instructions per cycle; issue pops up to two in program order (slot 0 is always older than slot 1). A flush input empties the queue on branch mispredict or exception redirect.

## Interface
- DATA_W, 32, width of one queue entry (instruction word).
- DEPTH, 8, number of entries; power of two, minimum 4.
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- i_flush  input  1  empties the queue; higher priority than all traffic.
- i_in_valid0  input  1  write slot 0 carries an instruction.
- i_in_valid1  input  1  write slot 1 carries an instruction; honoured only with i_in_valid0.
- i_in_data0, i_in_data1  input  DATA_W  write data; slot 0 is older.
- o_in_ready  output  1  at least two entries are free.
- o_out_valid0, o_out_valid1  output  1  head entry / second entry present.
- o_out_data0, o_out_data1  output  DATA_W  head / second entry; 0 when matching valid is low.
- i_out_take0  input  1  issue lane 0 consumes the head.
- i_out_take1  input  1  issue lane 1 consumes the second entry; honoured only with i_out_take0.
- o_count  output  $clog2(DEPTH)+1  current occupancy.

## Operation
- State: storage array mem[DEPTH], wr_ptr, rd_ptr ($clog2(DEPTH) bits, wrap modulo DEPTH), count.
- Effective write number wn: 0 if !o_in_ready or !i_in_valid0; 1 if i_in_valid0 only; 2 if both valids.
- i_in_valid1 without i_in_valid0: wn = 0, nothing written.
- Write: mem[wr_ptr] <= data0; if wn = 2, mem[wr_ptr+1] <= data1; wr_ptr += wn.
- Effective read number rn: take0 honoured only if o_out_valid0; take1 honoured only if take0 honoured and o_out_valid1; rn = 0..2.
- i_out_take1 without i_out_take0: rn = 0.
- rd_ptr += rn; count <= count + wn - rn.
- Simultaneous read and write in one cycle always permitted, including at count = 0 (write lands, nothing read) and count = DEPTH-2.
- o_in_ready = (DEPTH - count >= 2), derived from registered count only; same-cycle pops do not raise it.
- o_out_valid0 = count >= 1; o_out_valid1 = count >= 2; o_out_data0 = mem[rd_ptr]; o_out_data1 = mem[rd_ptr+1 mod DEPTH].
- Flush: wr_ptr, rd_ptr, count <= 0; writes and reads in the flush cycle discarded.
- Reset (rst_n low at edge): same as flush; mem not reset.
- Priority: reset > flush > normal traffic.

## Timing
- Write-to-visible latency: 1 cycle (data written at edge N is on o_out_data at N+1).
- Pop effect: next entries presented on the following cycle.
- Outputs after reset/flush: o_in_ready = 1, o_out_valid0/1 = 0, o_out_data0/1 = 0, o_count = 0.
- Full boundary: count = DEPTH-1 or DEPTH drops o_in_ready even if a single slot is free.
- Empty boundary: count = 0 ignores takes; count = 1 ignores take1.
- Pointer wrap: second-slot access at index DEPTH-1 uses entry 0 for both write and read.
- No combinational path from inputs to outputs.

## Structure
- DEPTH/DATA_W defaults and the instruction-word width go in the shared core defines include, next to the existing datapath width constants.
- No sub-module; storage is an inline register array. Pointer/count logic and output muxing in a single module.

## Test plan
- Reset, then push 0x11111111/0x22222222 (both valids) -> next cycle o_count = 2, o_out_data0 = 0x11111111, o_out_data1 = 0x22222222, both valids 1.
- Fill DEPTH=8 with four dual pushes -> o_in_ready = 0 at count 8; a fifth push is dropped, o_count stays 8; at count 7 o_in_ready also 0.
- Count 3, take0+take1 with a dual push in the same cycle -> o_count = 3, head becomes third-oldest entry, order preserved.
- Run 20 cycles of dual push/dual pop from count 0 -> pointers wrap; out_data sequence matches push sequence exactly.
- i_in_valid1 alone and i_out_take1 alone -> no state change; take0 at count 0 -> o_count stays 0.
- Count 5, assert i_flush with a dual push -> next cycle o_count = 0, both valids 0, data 0, o_in_ready 1; repeat with rst_n low, same result.

Source files
------------

// File: rtl/inst_queue_2w2r_pkg.sv
// inst_queue_2w2r_pkg: shared widths and helpers for the dual-port instruction queue
package inst_queue_2w2r_pkg;
   localparam int IQ_DATA_W = 32;
   localparam int IQ_DEPTH  = 8;
   // Number of slots actually moved when slot 1 is only honoured together with slot 0
   function automatic logic [1:0] slot_num(input logic s0, input logic s1);
      return s0 ? (s1 ? 2'd2 : 2'd1) : 2'd0;
   endfunction
endpackage

// File: rtl/inst_queue_2w2r.sv
// inst_queue_2w2r: in-order queue from fetch to two issue lanes, up to two pushes and two pops per cycle
module inst_queue_2w2r
   import inst_queue_2w2r_pkg::*;
#(
   parameter int DATA_W = IQ_DATA_W,
   parameter int DEPTH  = IQ_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_flush,
   input  logic                     i_in_valid0,
   input  logic                     i_in_valid1,
   input  logic [DATA_W-1:0]        i_in_data0,
   input  logic [DATA_W-1:0]        i_in_data1,
   output logic                     o_in_ready,
   output logic                     o_out_valid0,
   output logic                     o_out_valid1,
   output logic [DATA_W-1:0]        o_out_data0,
   output logic [DATA_W-1:0]        o_out_data1,
   input  logic                     i_out_take0,
   input  logic                     i_out_take1,
   output logic [$clog2(DEPTH):0]   o_count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_nx, rd_nx;
   logic [CW-1:0] count_q, count_d;
   logic [1:0] wn, rn;
   // Ready looks only at registered occupancy so no input reaches an output combinationally
   always_comb begin
      o_in_ready   = count_q <= CW'(DEPTH - 2);
      o_out_valid0 = count_q >= CW'(1);
      o_out_valid1 = count_q >= CW'(2);
      wr_nx        = wr_ptr_q + PW'(1);
      rd_nx        = rd_ptr_q + PW'(1);
      wn           = slot_num(o_in_ready && i_in_valid0, i_in_valid1);
      rn           = slot_num(i_out_take0 && o_out_valid0, i_out_take1 && o_out_valid1);
      wr_ptr_d     = wr_ptr_q + PW'(wn);
      rd_ptr_d     = rd_ptr_q + PW'(rn);
      count_d      = count_q + CW'(wn) - CW'(rn);
      o_out_data0  = o_out_valid0 ? mem_q[rd_ptr_q] : '0;
      o_out_data1  = o_out_valid1 ? mem_q[rd_nx] : '0;
      o_count      = count_q;
   end
   // Pointers and occupancy; reset beats flush, flush discards the cycle's traffic
   always_ff @(posedge clk) begin
      if (!rst_n || i_flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end
   // Storage is never cleared; the valids mask stale contents
   always_ff @(posedge clk) begin
      if (rst_n && !i_flush && wn != 2'd0) mem_q[wr_ptr_q] <= i_in_data0;
      if (rst_n && !i_flush && wn == 2'd2) mem_q[wr_nx] <= i_in_data1;
   end
endmodule

// File: tb/tb_inst_queue_2w2r.sv
// tb_inst_queue_2w2r: directed checks of the dual-write/dual-read instruction queue
module tb_inst_queue_2w2r;
   logic        clk = 1'b0;
   logic        rst_n, i_flush, i_in_valid0, i_in_valid1, i_out_take0, i_out_take1;
   logic [31:0] i_in_data0, i_in_data1;
   logic        o_in_ready, o_out_valid0, o_out_valid1;
   logic [31:0] o_out_data0, o_out_data1;
   logic [3:0]  o_count;
   int total = 0, bad = 0;

   inst_queue_2w2r #(.DATA_W(32), .DEPTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .i_flush(i_flush),
      .i_in_valid0(i_in_valid0), .i_in_valid1(i_in_valid1),
      .i_in_data0(i_in_data0), .i_in_data1(i_in_data1),
      .o_in_ready(o_in_ready), .o_out_valid0(o_out_valid0), .o_out_valid1(o_out_valid1),
      .o_out_data0(o_out_data0), .o_out_data1(o_out_data1),
      .i_out_take0(i_out_take0), .i_out_take1(i_out_take1), .o_count(o_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One clock with the given inputs applied, then inputs return to idle
   task automatic cyc(input logic v0, input logic v1, input logic [31:0] a, input logic [31:0] b,
                      input logic t0, input logic t1, input logic fl, input logic rn);
      i_in_valid0 = v0; i_in_valid1 = v1; i_in_data0 = a; i_in_data1 = b;
      i_out_take0 = t0; i_out_take1 = t1; i_flush = fl; rst_n = rn;
      @(posedge clk); #1;
      i_in_valid0 = 0; i_in_valid1 = 0; i_in_data0 = 0; i_in_data1 = 0;
      i_out_take0 = 0; i_out_take1 = 0; i_flush = 0; rst_n = 1;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_cnt"}, 32'(o_count), 0);
      chk({tag, "_rdy"}, 32'(o_in_ready), 1);
      chk({tag, "_v0"}, 32'(o_out_valid0), 0);
      chk({tag, "_v1"}, 32'(o_out_valid1), 0);
      chk({tag, "_d0"}, o_out_data0, 0);
      chk({tag, "_d1"}, o_out_data1, 0);
   endtask

   initial begin
      cyc(0, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0);
      chk_idle("reset");
      // first dual push
      cyc(1, 1, 32'h11111111, 32'h22222222, 0, 0, 0, 1);
      chk("push_cnt", 32'(o_count), 2);
      chk("push_d0", o_out_data0, 32'h11111111);
      chk("push_d1", o_out_data1, 32'h22222222);
      chk("push_v0", 32'(o_out_valid0), 1);
      chk("push_v1", 32'(o_out_valid1), 1);
      // fill to 8
      cyc(1, 1, 32'h33333333, 32'h44444444, 0, 0, 0, 1);
      cyc(1, 1, 32'h55555555, 32'h66666666, 0, 0, 0, 1);
      chk("cnt6_rdy", 32'(o_in_ready), 1);
      cyc(1, 1, 32'h77777777, 32'h88888888, 0, 0, 0, 1);
      chk("full_cnt", 32'(o_count), 8);
      chk("full_rdy", 32'(o_in_ready), 0);
      cyc(1, 1, 32'h99999999, 32'h99999999, 0, 0, 0, 1);
      chk("drop_cnt", 32'(o_count), 8);
      chk("drop_d0", o_out_data0, 32'h11111111);
      // single pop to 7: still not ready
      cyc(0, 0, 0, 0, 1, 0, 0, 1);
      chk("cnt7_cnt", 32'(o_count), 7);
      chk("cnt7_rdy", 32'(o_in_ready), 0);
      chk("cnt7_d0", o_out_data0, 32'h22222222);
      chk("cnt7_d1", o_out_data1, 32'h33333333);
      cyc(1, 1, 32'h99999999, 32'h99999999, 0, 0, 0, 1);
      chk("cnt7_drop", 32'(o_count), 7);
      // pop down to 3
      cyc(0, 0, 0, 0, 1, 1, 0, 1);
      cyc(0, 0, 0, 0, 1, 1, 0, 1);
      chk("cnt3_cnt", 32'(o_count), 3);
      chk("cnt3_d0", o_out_data0, 32'h66666666);
      // dual pop with dual push at count 3
      cyc(1, 1, 32'hAAAAAAAA, 32'hBBBBBBBB, 1, 1, 0, 1);
      chk("rw_cnt", 32'(o_count), 3);
      chk("rw_d0", o_out_data0, 32'h88888888);
      chk("rw_d1", o_out_data1, 32'hAAAAAAAA);
      cyc(0, 0, 0, 0, 1, 0, 0, 1);
      chk("rw_order", o_out_data1, 32'hBBBBBBBB);
      // count 5 then flush with push
      cyc(1, 1, 32'hCCCCCCCC, 32'hDDDDDDDD, 0, 0, 0, 1);
      cyc(1, 0, 32'hEEEEEEEE, 0, 0, 0, 0, 1);
      chk("pre_flush", 32'(o_count), 5);
      cyc(1, 1, 32'h12345678, 32'h9ABCDEF0, 1, 1, 1, 1);
      chk_idle("flush");
      // offset pointers by one so pair writes straddle index 7 -> 0
      cyc(1, 0, 32'h0BADF00D, 0, 0, 0, 0, 1);
      chk("single_d0", o_out_data0, 32'h0BADF00D);
      chk("single_v1", 32'(o_out_valid1), 0);
      cyc(0, 0, 0, 0, 1, 1, 0, 1);
      chk("cnt1_take1", 32'(o_count), 0);
      cyc(0, 0, 0, 0, 1, 0, 0, 1);
      chk("take_empty", 32'(o_count), 0);
      // streaming dual push / dual pop with wrap
      for (int i = 0; i < 20; i++) begin
         cyc(1, 1, 32'h10000000 + 32'(2*i), 32'h10000000 + 32'(2*i+1), 1, 1, 0, 1);
         chk($sformatf("strm%0d_d0", i), o_out_data0, 32'h10000000 + 32'(2*i));
         chk($sformatf("strm%0d_d1", i), o_out_data1, 32'h10000000 + 32'(2*i+1));
      end
      chk("strm_cnt", 32'(o_count), 2);
      // lone slot-1 strobes do nothing
      cyc(0, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, 1);
      chk("v1only_cnt", 32'(o_count), 2);
      cyc(0, 0, 0, 0, 0, 1, 0, 1);
      chk("t1only_cnt", 32'(o_count), 2);
      chk("t1only_d0", o_out_data0, 32'h10000026);
      // count 5 then reset with push
      cyc(1, 1, 32'h01010101, 32'h02020202, 0, 0, 0, 1);
      cyc(1, 0, 32'h03030303, 0, 0, 0, 0, 1);
      chk("pre_rst", 32'(o_count), 5);
      cyc(1, 1, 32'h12345678, 32'h9ABCDEF0, 1, 1, 0, 0);
      chk_idle("rstn");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
